// File: rtl/div3_serial_tx.sv
// div3_serial_tx: parallel-in / serial-out transmitter (MSB first) that tracks
// the running value of the emitted frame prefix modulo 3.
// Optional feature macro: DIV3_TX_PAD_EN appends two pad bits after the LSB.
// The pad makes every frame value a multiple of 3.
module div3_serial_tx #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 x_o,
    output logic                 x_valid_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic [1:0]           rem_o,
    output logic                 div_o
);

    localparam int CNT_W = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LSB    = CNT_W'(DATAWIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRELSB = CNT_W'(DATAWIDTH - 2);

`ifdef DIV3_TX_PAD_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    // Remainder update (2*r + b) mod 3 as an explicit table; never yields 3.
    function automatic logic [1:0] rem_next(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd0:    n = b ? 2'd1 : 2'd0;
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

`ifdef DIV3_TX_PAD_EN
    // Two-bit pad that brings the frame value to a multiple of 3: (3 - r) mod 3.
    function automatic logic [1:0] pad_value(input logic [1:0] r);
        logic [1:0] p;
        case (r)
            2'd0:    p = 2'd0;
            2'd1:    p = 2'd2;
            2'd2:    p = 2'd1;
            default: p = 2'd0;
        endcase
        return p;
    endfunction
`endif

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 x_q, x_d;
    logic                 x_valid_q, x_valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic [1:0]           rem_q, rem_d;
    logic                 ready_s;
    logic                 accept_s;
`ifdef DIV3_TX_PAD_EN
    logic [1:0]           pad_s;
`endif

    // Ready when idle or while the final frame bit is on the line.
    always_comb begin
        ready_s  = (state_q == ST_IDLE) || last_q;
        accept_s = valid_i && ready_s;
    end

    // Next-state, shift, counter and output-bit computation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        first_d   = first_q;
        last_d    = last_q;
        rem_d     = rem_q;
`ifdef DIV3_TX_PAD_EN
        pad_s     = 2'b00;
`endif
        if (accept_s) begin
            // New frame: MSB goes out next cycle, remainder restarts from it.
            state_d   = ST_SHIFT;
            x_d       = data_i[DATAWIDTH-1];
            shift_d   = {data_i[DATAWIDTH-2:0], 1'b0};
            cnt_d     = {CNT_W{1'b0}};
            x_valid_d = 1'b1;
            first_d   = 1'b1;
            last_d    = 1'b0;
            rem_d     = {1'b0, data_i[DATAWIDTH-1]};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_IDLE;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                    first_d   = 1'b0;
                    last_d    = 1'b0;
                end
                ST_SHIFT: begin
`ifdef DIV3_TX_PAD_EN
                    if (cnt_q == CNT_LSB) begin
                        // LSB is on the line; first pad bit follows.
                        pad_s   = pad_value(rem_q);
                        state_d = ST_PAD;
                        x_d     = pad_s[1];
                        shift_d = {pad_s[0], {(DATAWIDTH-1){1'b0}}};
                        rem_d   = rem_next(rem_q, pad_s[1]);
                        first_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        x_d     = shift_q[DATAWIDTH-1];
                        shift_d = {shift_q[DATAWIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                        rem_d   = rem_next(rem_q, shift_q[DATAWIDTH-1]);
                        first_d = 1'b0;
                        last_d  = 1'b0;
                    end
`else
                    if (last_q) begin
                        // Frame done with no follow-on word.
                        state_d   = ST_IDLE;
                        shift_d   = {DATAWIDTH{1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        x_d       = 1'b0;
                        x_valid_d = 1'b0;
                        first_d   = 1'b0;
                        last_d    = 1'b0;
                    end else begin
                        x_d     = shift_q[DATAWIDTH-1];
                        shift_d = {shift_q[DATAWIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                        rem_d   = rem_next(rem_q, shift_q[DATAWIDTH-1]);
                        first_d = 1'b0;
                        last_d  = (cnt_q == CNT_PRELSB);
                    end
`endif
                end
`ifdef DIV3_TX_PAD_EN
                ST_PAD: begin
                    if (last_q) begin
                        state_d   = ST_IDLE;
                        shift_d   = {DATAWIDTH{1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        x_d       = 1'b0;
                        x_valid_d = 1'b0;
                        first_d   = 1'b0;
                        last_d    = 1'b0;
                    end else begin
                        x_d     = shift_q[DATAWIDTH-1];
                        shift_d = {shift_q[DATAWIDTH-2:0], 1'b0};
                        rem_d   = rem_next(rem_q, shift_q[DATAWIDTH-1]);
                        first_d = 1'b0;
                        last_d  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d   = ST_IDLE;
                    shift_d   = {DATAWIDTH{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                    first_d   = 1'b0;
                    last_d    = 1'b0;
                    rem_d     = 2'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= {DATAWIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            rem_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
        end
    end

    // Output drive; div_o is gated by x_valid so it stays low in IDLE.
    always_comb begin
        ready_o   = ready_s;
        x_o       = x_q;
        x_valid_o = x_valid_q;
        first_o   = first_q;
        last_o    = last_q;
        rem_o     = rem_q;
        div_o     = x_valid_q && (rem_q == 2'd0);
    end

endmodule

// File: tb/tb_div3_serial_tx.sv
// Self-checking bench for div3_serial_tx: vector table for one frame, directed
// corner-case sequences, and random traffic against a frame-level model.
module tb_div3_serial_tx;

    localparam int DW = 8;
`ifdef DIV3_TX_PAD_EN
    localparam int FL  = DW + 2;
    localparam bit PAD = 1'b1;
`else
    localparam int FL  = DW;
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o, x_o, x_valid_o, first_o, last_o, div_o;
    logic [1:0]    rem_o;

    div3_serial_tx #(.DATAWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .x_o(x_o), .x_valid_o(x_valid_o),
        .first_o(first_o), .last_o(last_o), .rem_o(rem_o), .div_o(div_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model: bit list of the current frame and position.
    logic m_fb [0:DW+1];
    int   m_pos = -1;
    int   m_last_rem = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_frame(input logic [DW-1:0] d);
        int r;
        logic [1:0] p;
        for (int i = 0; i < DW; i++) m_fb[i] = d[DW-1-i];
        r = int'(d) % 3;
        p = 2'((3 - r) % 3);
        m_fb[DW]   = PAD ? p[1] : 1'b0;
        m_fb[DW+1] = PAD ? p[0] : 1'b0;
    endtask

    function automatic int prefix_rem(input int k);
        int v = 0;
        for (int i = 0; i <= k; i++) v = v * 2 + int'(m_fb[i]);
        return v % 3;
    endfunction

    function automatic bit exp_ready();
        return (m_pos < 0) || (m_pos == FL - 1);
    endfunction

    task automatic check_model();
        int er;
        er = (m_pos < 0) ? m_last_rem : prefix_rem(m_pos);
        chk("x",       x_o,       (m_pos < 0) ? 0 : m_fb[m_pos]);
        chk("x_valid", x_valid_o, (m_pos < 0) ? 0 : 1);
        chk("first",   first_o,   (m_pos == 0) ? 1 : 0);
        chk("last",    last_o,    (m_pos >= 0 && m_pos == FL - 1) ? 1 : 0);
        chk("rem",     rem_o,     er);
        chk("div",     div_o,     (m_pos >= 0 && er == 0) ? 1 : 0);
        chk("ready",   ready_o,   exp_ready() ? 1 : 0);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
        bit acc;
        valid_i = v;
        data_i  = d;
        acc = v && exp_ready();
        @(posedge clk);
        if (acc) begin
            load_frame(d);
            m_pos = 0;
        end else if (m_pos >= 0 && m_pos == FL - 1) begin
            m_last_rem = prefix_rem(FL - 1);
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos++;
        end
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ex, exv, ef, el, erdy, ediv;
        logic [1:0]    er;
    } vec_t;

    vec_t tbl [0:10];
    int   n_vec;

    task automatic set_vec(input int i, input logic v, input logic [DW-1:0] d,
                           input logic ex, input logic exv, input logic ef, input logic el,
                           input logic erdy, input logic [1:0] er, input logic ediv);
        tbl[i].v = v;  tbl[i].d = d;  tbl[i].ex = ex; tbl[i].exv = exv;
        tbl[i].ef = ef; tbl[i].el = el; tbl[i].erdy = erdy; tbl[i].er = er; tbl[i].ediv = ediv;
    endtask

    initial begin
        logic [1:0]    exp03 [0:7];
        logic [DW-1:0] got;
        int            xv_cnt, first_cnt, bound;
        bit            first_at_fl;

        // 0x96 frame: bits 1,0,0,1,0,1,1,0 / rem 1,2,1,0,0,1,0,0.
        set_vec(0, 1'b1, 8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        set_vec(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        set_vec(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        set_vec(3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        set_vec(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        set_vec(5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        set_vec(6, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        if (PAD) begin
            set_vec(7,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
            set_vec(8,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
            set_vec(9,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
            set_vec(10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
            n_vec = 11;
        end else begin
            set_vec(7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
            set_vec(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
            n_vec = 9;
        end
        exp03[0] = 2'd0; exp03[1] = 2'd0; exp03[2] = 2'd0; exp03[3] = 2'd0;
        exp03[4] = 2'd0; exp03[5] = 2'd0; exp03[6] = 2'd1; exp03[7] = 2'd0;

        // Reset state.
        reset = 1'b1; valid_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        check_model();
        reset = 1'b0;

        // Table-driven 0x96 frame.
        for (int i = 0; i < n_vec; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            chk("tbl_x",     x_o,       tbl[i].ex);
            chk("tbl_xv",    x_valid_o, tbl[i].exv);
            chk("tbl_first", first_o,   tbl[i].ef);
            chk("tbl_last",  last_o,    tbl[i].el);
            chk("tbl_ready", ready_o,   tbl[i].erdy);
            chk("tbl_rem",   rem_o,     tbl[i].er);
            chk("tbl_div",   div_o,     tbl[i].ediv);
        end

        // 0x07: final remainder 1 without pad, 0 with pad bits 1,0.
        cycle(1'b1, 8'h07);
        for (int i = 1; i < FL; i++) cycle(1'b0, 8'h00);
        chk("x07_last", last_o, 1);
        chk("x07_rem",  rem_o,  PAD ? 0 : 1);
        chk("x07_div",  div_o,  PAD ? 1 : 0);
        cycle(1'b0, 8'h00);

        // Back-to-back 0xFF then 0x01 with valid held high.
        xv_cnt = 0; first_cnt = 0; first_at_fl = 1'b0;
        cycle(1'b1, 8'hFF);
        xv_cnt += int'(x_valid_o); first_cnt += int'(first_o);
        for (int i = 1; i <= FL; i++) begin
            cycle(1'b1, 8'h01);
            xv_cnt += int'(x_valid_o); first_cnt += int'(first_o);
            if (i == FL) first_at_fl = first_o;
        end
        for (int i = 1; i < FL; i++) begin
            cycle(1'b0, 8'h00);
            xv_cnt += int'(x_valid_o); first_cnt += int'(first_o);
        end
        chk("b2b_xv_run",   xv_cnt, 2 * FL);
        chk("b2b_first_n",  first_cnt, 2);
        chk("b2b_first_at", first_at_fl, 1);
        cycle(1'b0, 8'h00);
        chk("b2b_idle_xv", x_valid_o, 0);

        // 0xAA offered mid-frame: held until accepted, then sent intact.
        cycle(1'b1, 8'h96);
        cycle(1'b0, 8'h00);
        bound = 0;
        do begin
            cycle(1'b1, 8'hAA);
            bound++;
        end while (!(m_pos == 0 && first_o === 1'b1) && bound < 3 * FL);
        chk("aa_accept_cycles", bound, FL - 1);
        got = '0;
        got = {got[DW-2:0], x_o};
        for (int i = 1; i < DW; i++) begin
            cycle(1'b0, 8'h00);
            got = {got[DW-2:0], x_o};
        end
        chk("aa_word", got, 8'hAA);
        for (int i = 0; i < FL - DW + 1; i++) cycle(1'b0, 8'h00);

        // Asynchronous reset on bit 3 of 0x96, then 0x03.
        cycle(1'b1, 8'h96);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        reset = 1'b1;
        #1;
        m_pos = -1; m_last_rem = 0;
        check_model();
        @(negedge clk);
        check_model();
        reset = 1'b0;
        cycle(1'b1, 8'h03);
        chk("rst_rem0", rem_o, exp03[0]);
        for (int i = 1; i < DW; i++) begin
            cycle(1'b0, 8'h00);
            chk("rst_rem", rem_o, exp03[i]);
        end
        for (int i = DW; i <= FL; i++) cycle(1'b0, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div3_serial_tx.md
Name: div3_serial_tx

Overview:
- Transmit-side companion to the serial divide-by-three checker.
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first, one bit per clock, onto a single-bit stream (`x_o`).
- Tracks the running remainder mod 3 of the emitted prefix, so the transmitter and downstream checker can be compared bit-for-bit.
- Sits between a word source and the serial divisibility checker.

Parameters:
- DATAWIDTH, 8: width of the parallel input word and number of data bits per frame; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- data_i  in  DATAWIDTH  parallel word, unsigned, sent MSB first
- valid_i  in  1  data_i valid
- ready_o  out  1  block can accept a word this cycle
- x_o  out  1  serial data bit
- x_valid_o  out  1  x_o carries a frame bit this cycle
- first_o  out  1  x_o is the first bit of a frame
- last_o  out  1  x_o is the final bit of a frame
- rem_o  out  2  (value of frame prefix up to and including x_o) mod 3; range 0..2
- div_o  out  1  x_valid_o && (rem_o == 0)

Behaviour:
- Reset (async assert, any state): FSM to IDLE, shift register and bit counter cleared.
  - Outputs on reset: ready_o=1, x_o=0, x_valid_o=0, first_o=0, last_o=0, rem_o=0, div_o=0.
  - An in-flight frame is discarded and never resumed.
- Handshake: a word is accepted on a rising edge where valid_i && ready_o. data_i is captured at that edge; it may change afterwards.
- ready_o is combinational from state:
  - 1 in IDLE.
  - 1 on the cycle where last_o=1.
  - 0 otherwise.
- FSM states: IDLE, SHIFT, PAD (PAD exists only with the optional feature).
- IDLE:
  - On accept: go to SHIFT. At the same edge, load the MSB onto x_o, set x_valid_o=1, first_o=1, and rem_o = MSB.
  - Latency: first bit is visible the cycle after the accept edge.
- SHIFT:
  - Each edge presents the next lower bit b and updates the remainder as rem <= (2*rem + b) mod 3.
  - first_o is high only on bit 0 of the frame.
  - The bit counter counts 0..DATAWIDTH-1.
  - Without the feature, last_o=1 with the LSB.
- End of frame:
  - If a new word is accepted at the last-bit edge: restart the frame directly. The new MSB appears next cycle and rem restarts from MSB, not from the old remainder. There is no idle gap, and x_valid_o stays high.
  - Otherwise: go to IDLE and clear x_valid_o, first_o, last_o. x_o goes to 0. rem_o holds the final frame remainder until the next frame starts. div_o is forced 0 in IDLE by the x_valid_o gating.
- valid_i held high while busy: no accept until ready_o=1; the word is not lost.
- Remainder arithmetic: 2-bit register. The update is a 3-state table and must never produce the value 3.

Optional Feature:
- Macro: DIV3_TX_PAD_EN
- Defined:
  - After the LSB, the FSM enters PAD and emits 2 pad bits, MSB first.
  - Pad value p = (3 - r) mod 3, where r is the remainder after the LSB.
  - Frame length is DATAWIDTH+2. Every frame value is divisible by 3, so div_o=1 on the last pad bit.
  - last_o is asserted on the second pad bit only; ready_o and back-to-back acceptance move to that cycle.
- Not defined:
  - PAD state and pad logic are absent; frame length is DATAWIDTH.

Test Plan:
- DATAWIDTH=8, send 0x96 (150):
  - x_o = 1,0,0,1,0,1,1,0.
  - rem_o = 1,2,1,0,0,1,0,0.
  - div_o = 0,0,0,1,1,0,1,1.
  - first_o on bit 0, last_o on bit 7; ready_o=0 on bits 0..6.
- Send 0x07 (7), without PAD_EN: final rem_o=1, div_o=0 on the last bit.
- Send 0x07 (7), with DIV3_TX_PAD_EN:
  - Pad bits 1,0 (7*4+2 = 30).
  - rem_o on pad bits = 0,0; last_o on the 10th bit; div_o=1.
- Back-to-back 0xFF then 0x01, with valid_i held high:
  - x_valid_o high for 16 consecutive cycles.
  - Second frame rem_o = 0,0,0,0,0,0,0,1.
  - first_o pulses at cycles 0 and 8.
- valid_i=1 with 0xAA while mid-frame → no capture until the last-bit cycle; 0xAA is sent next, intact.
- reset asserted on bit 3 of 0x96:
  - Outputs zero immediately, asynchronously, and ready_o=1.
  - After release, a new 0x03 transmits from its MSB with rem_o = 0,0,0,0,0,0,1,0.
